// File: rtl/one_to_four_demux_stream_pkg.sv
// Shared constants and FSM state type for the 1-to-4 stream demux.
// Imported by the interface, the output slot and the top.
package demux_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE,
        LOCKED
    } demux_state_t;
endpackage

// File: rtl/one_to_four_demux_stream_if.sv
// Stream bundle: one shared source side, four consumer lanes, counters.
// master drives the source/consumer side, slave is the demux.
interface one_to_four_demux_stream_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    import demux_pkg::*;

    logic [WIDTH-1:0]        in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_last;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic [NUM_CH-1:0]       out_last;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH-1:0]       out_ready;
    logic                    busy;
    logic [NUM_CH*CNT_W-1:0] cnt;
    logic                    cnt_clr;

    modport master (
        output in_data, in_sel, in_last, in_valid,
        output out_ready, cnt_clr,
        input  in_ready, out_data, out_last, out_valid,
        input  busy, cnt
    );

    modport slave (
        input  in_data, in_sel, in_last, in_valid,
        input  out_ready, cnt_clr,
        output in_ready, out_data, out_last, out_valid,
        output busy, cnt
    );
endinterface

// File: rtl/one_to_four_demux_stream_slot.sv
// One-entry output register slot with a delivered-beat counter.
// A load in the same cycle as a drain replaces the beat and keeps valid high.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    input  logic             i_ready,
    input  logic             i_clr,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    output logic [CNT_W-1:0] o_cnt
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             w_drain;

    assign w_drain = r_valid & i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    // Clear wins over a coincident drain.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (w_drain) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_cnt   = r_cnt;
endmodule

// File: rtl/one_to_four_demux_stream.sv
// Streaming 1-to-4 demux: packets stay locked to the channel chosen
// by in_sel on their first beat; each channel has a one-entry slot.
module one_to_four_demux_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic                        clk,
    input logic                        rst,
    one_to_four_demux_stream_if.slave  bus
);
    demux_state_t     r_state;
    demux_state_t     w_state_nxt;
    logic [SEL_W-1:0] r_lock_sel;
    logic [SEL_W-1:0] w_lock_sel_nxt;
    logic [SEL_W-1:0] w_route;
    logic             w_in_ready;
    logic             w_accept;

    logic [NUM_CH-1:0] w_valid;
    logic [NUM_CH-1:0] w_last;
    logic [WIDTH-1:0]  w_data [NUM_CH];
    logic [CNT_W-1:0]  w_cnt  [NUM_CH];

    assign w_route    = (r_state == IDLE) ? bus.in_sel : r_lock_sel;
    assign w_in_ready = ~w_valid[w_route] | bus.out_ready[w_route];
    assign w_accept   = bus.in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lock_sel <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_sel <= w_lock_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_sel_nxt = r_lock_sel;
        unique case (r_state)
            IDLE: begin
                if (w_accept && !bus.in_last) begin
                    w_state_nxt    = LOCKED;
                    w_lock_sel_nxt = bus.in_sel;
                end
            end
            LOCKED: begin
                if (w_accept && bus.in_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_out_slot #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_accept && (w_route == SEL_W'(k))),
            .i_data  (bus.in_data),
            .i_last  (bus.in_last),
            .i_ready (bus.out_ready[k]),
            .i_clr   (bus.cnt_clr),
            .o_valid (w_valid[k]),
            .o_data  (w_data[k]),
            .o_last  (w_last[k]),
            .o_cnt   (w_cnt[k])
        );
    end

    always_comb begin
        bus.out_data = '0;
        bus.cnt      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            bus.out_data[k*WIDTH +: WIDTH] = w_data[k];
            bus.cnt[k*CNT_W +: CNT_W]      = w_cnt[k];
        end
    end

    assign bus.out_valid = w_valid;
    assign bus.out_last  = w_last;
    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = (r_state == LOCKED);
endmodule

// File: tb/tb_one_to_four_demux_stream.sv
// Bench for the 1-to-4 stream demux: per-channel scoreboard queues
// plus directed checks for reset, lock, backpressure and counters.
module tb_one_to_four_demux_stream;
    import demux_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;

    one_to_four_demux_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    one_to_four_demux_stream #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard model: queue k holds {last,data} of the beat in slot k.
    logic [WIDTH:0]  sb_q [NUM_CH][$];
    logic [CNT_W-1:0] cnt_m [NUM_CH];
    logic             st_m = 1'b0;
    logic [1:0]       lock_m = '0;
    logic             mon_en = 1'b0;

    function automatic logic [WIDTH-1:0] lane(input int k);
        return bus.out_data[k*WIDTH +: WIDTH];
    endfunction

    function automatic logic [CNT_W-1:0] cntl(input int k);
        return bus.cnt[k*CNT_W +: CNT_W];
    endfunction

    always @(negedge clk) begin
        logic [1:0] rt;
        logic       er;
        logic       dr;
        rt = st_m ? lock_m : bus.in_sel;
        er = (sb_q[rt].size() == 0) || bus.out_ready[rt];
        if (mon_en) begin
            check("busy", {31'b0, bus.busy}, {31'b0, st_m});
            check("in_ready", {31'b0, bus.in_ready}, {31'b0, er});
            for (int k = 0; k < NUM_CH; k++) begin
                check("out_valid", {31'b0, bus.out_valid[k]},
                      {31'b0, sb_q[k].size() != 0});
                check("cnt", {28'b0, cntl(k)}, {28'b0, cnt_m[k]});
                if (sb_q[k].size() != 0)
                    check("sb_beat", {23'b0, bus.out_last[k], lane(k)},
                          {23'b0, sb_q[k][0]});
            end
        end
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                sb_q[k].delete();
                cnt_m[k] = '0;
            end
            st_m   = 1'b0;
            lock_m = '0;
            mon_en = 1'b1;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                dr = (sb_q[k].size() != 0) && bus.out_ready[k];
                if (bus.cnt_clr) cnt_m[k] = '0;
                else if (dr) cnt_m[k] = cnt_m[k] + 1'b1;
                if (dr) void'(sb_q[k].pop_front());
            end
            if (bus.in_valid && er) begin
                sb_q[rt].push_back({bus.in_last, bus.in_data});
                if (!st_m && !bus.in_last) begin
                    st_m   = 1'b1;
                    lock_m = bus.in_sel;
                end else if (st_m && bus.in_last) begin
                    st_m = 1'b0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] d, input logic [1:0] s,
                        input logic l);
        int n;
        n = 0;
        bus.in_data  = d;
        bus.in_sel   = s;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 50);
        if (!bus.in_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    logic [7:0] p3_d [3];
    logic [1:0] p3_s [3];

    initial begin
        p3_d = '{8'h11, 8'h22, 8'h33};
        p3_s = '{2'd1, 2'd3, 2'd0};
        rst           = 1'b1;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        bus.cnt_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Fill all slots and leave a packet open, then reset.
        send(8'hB1, 2'd1, 1'b1);
        send(8'hB2, 2'd2, 1'b1);
        send(8'hB3, 2'd3, 1'b1);
        send(8'hB0, 2'd0, 1'b0);
        @(negedge clk);
        check("pre_rst_valid", {28'b0, bus.out_valid}, 32'hF);
        check("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {28'b0, bus.out_valid}, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_cnt", {16'b0, bus.cnt}, 32'h0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Single beat to channel 2.
        @(posedge clk);
        #1 bus.out_ready = 4'b1111;
        send(8'hA5, 2'd2, 1'b1);
        @(negedge clk);
        check("single_valid", {28'b0, bus.out_valid}, 32'h4);
        check("single_lane2", {24'b0, lane(2)}, 32'hA5);
        check("single_last2", {31'b0, bus.out_last[2]}, 32'd1);
        @(negedge clk);
        check("single_cnt2", {28'b0, cntl(2)}, 32'd1);

        // Packet lock: in_sel changes after the first beat are ignored.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            send(p3_d[i], p3_s[i], i == 2);
            @(negedge clk);
            check("lock_lane1", {24'b0, lane(1)}, {24'b0, p3_d[i]});
            check("lock_valid", {28'b0, bus.out_valid}, 32'h2);
            check("lock_busy", {31'b0, bus.busy}, {31'b0, i < 2});
        end

        // Backpressure on channel 0 and same-cycle drain+load.
        @(posedge clk);
        #1 bus.out_ready = 4'b1110;
        send(8'h44, 2'd0, 1'b1);
        bus.in_data  = 8'h55;
        bus.in_sel   = 2'd0;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("bp_hold", {24'b0, lane(0)}, 32'h44);
        @(posedge clk);
        #1 bus.out_ready = 4'b1111;
        @(negedge clk);
        check("bp_release", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_new_valid", {31'b0, bus.out_valid[0]}, 32'd1);
        check("bp_new_lane0", {24'b0, lane(0)}, 32'h55);

        // Stalled channel 3 must not block a packet streaming to channel 1.
        @(posedge clk);
        #1 bus.out_ready = 4'b0111;
        send(8'h99, 2'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus.in_data  = 8'(8'h60 + i);
            bus.in_sel   = 2'd1;
            bus.in_last  = (i == 3);
            bus.in_valid = 1'b1;
            @(negedge clk);
            check("ch1_nostall", {31'b0, bus.in_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("ind_valid3", {31'b0, bus.out_valid[3]}, 32'd1);
        check("ind_lane3", {24'b0, lane(3)}, 32'h99);
        check("ind_lane1", {24'b0, lane(1)}, 32'h63);

        // Counter wrap after 17 drains, then clear racing a drain.
        @(posedge clk);
        #1 bus.out_ready = 4'b1111;
        bus.cnt_clr = 1'b1;
        @(posedge clk);
        #1 bus.cnt_clr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus.in_data  = 8'(i);
            bus.in_sel   = 2'd0;
            bus.in_last  = 1'b1;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("cnt_wrap", {28'b0, cntl(0)}, 32'd1);
        @(posedge clk);
        #1;
        send(8'h77, 2'd0, 1'b1);
        bus.cnt_clr = 1'b1;
        @(posedge clk);
        #1 bus.cnt_clr = 1'b0;
        @(negedge clk);
        check("cnt_clr_prio", {28'b0, cntl(0)}, 32'd0);
        check("clr_drained", {31'b0, bus.out_valid[0]}, 32'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
